// File: rtl/fetch_sequencer_if.sv
// Local-store line-fetch port: req/addr out, grant/rvalid/rdata back.
// master = fetch_sequencer, slave = local-store arbiter.
interface fetch_sequencer_if #(
  parameter int PC_WIDTH = 8,
  parameter int INSTR_W  = 32
);
  logic                   ls_req;
  logic [PC_WIDTH-1:0]    ls_addr;
  logic                   ls_grant;
  logic                   ls_rvalid;
  logic [2*INSTR_W-1:0]   ls_rdata;

  modport master (
    output ls_req,
    output ls_addr,
    input  ls_grant,
    input  ls_rvalid,
    input  ls_rdata
  );

  modport slave (
    input  ls_req,
    input  ls_addr,
    output ls_grant,
    output ls_rvalid,
    output ls_rdata
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Line fetch into an instruction buffer, dual-issue head for decode.
// Ports: i_clk/i_reset, ls (line port), branch, stall/issue, instr/pc/valid.
module fetch_sequencer #(
  parameter int PC_WIDTH  = 8,
  parameter int BUF_DEPTH = 8,
  parameter int INSTR_W   = 32
) (
  input  logic                i_clk,
  input  logic                i_reset,
  fetch_sequencer_if.master   ls,
  input  logic                i_branch_taken,
  input  logic [PC_WIDTH-1:0] i_branch_target,
  input  logic                i_stall,
  input  logic [1:0]          i_issue_count,
  output logic [INSTR_W-1:0]  o_instr0,
  output logic [INSTR_W-1:0]  o_instr1,
  output logic [PC_WIDTH-1:0] o_pc0,
  output logic                o_valid0,
  output logic                o_valid1
);

  localparam int AW = $clog2(BUF_DEPTH);
  localparam int CW = AW + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_REQ   = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  logic [1:0]          r_state;
  logic [PC_WIDTH-1:0] r_fetch_pc;
  logic [PC_WIDTH-1:0] r_line_pc;
  logic [AW-1:0]       r_head;
  logic [AW-1:0]       r_tail;
  logic [CW-1:0]       r_count;
  logic [INSTR_W-1:0]  r_instr [BUF_DEPTH];
  logic [PC_WIDTH-1:0] r_pc    [BUF_DEPTH];

  logic [1:0]          w_state_nx;
  logic [PC_WIDTH-1:0] w_fpc_nx;
  logic [CW-1:0]       w_pop;
  logic [CW-1:0]       w_count_nx;
  logic                w_wr;
  logic                w_room;
  logic                w_grant;

  // Pops are clamped so a bad issue_count can never underflow.
  always_comb begin
    w_pop = '0;
    if (!i_branch_taken && !i_stall) begin
      if (CW'(i_issue_count) > r_count)
        w_pop = r_count;
      else
        w_pop = CW'(i_issue_count);
    end
  end

  assign w_wr    = (r_state == S_WAIT) && ls.ls_rvalid
                   && !i_branch_taken;
  assign w_grant = (r_state == S_REQ) && ls.ls_grant;

  always_comb begin
    w_count_nx = '0;
    if (!i_branch_taken)
      w_count_nx = r_count - w_pop
                   + (w_wr ? CW'(2) : CW'(0));
  end

  // Room for a whole line after this cycle's write and pops.
  assign w_room = (w_count_nx <= CW'(BUF_DEPTH - 2));

  always_comb begin
    w_state_nx = r_state;
    w_fpc_nx   = r_fetch_pc;
    unique case (r_state)
      S_IDLE: begin
        if (i_branch_taken)
          w_fpc_nx = i_branch_target;
        else if (w_room)
          w_state_nx = S_REQ;
      end
      S_REQ: begin
        if (i_branch_taken) begin
          w_fpc_nx   = i_branch_target;
          // A grant this cycle leaves a line in flight to discard.
          w_state_nx = ls.ls_grant ? S_DRAIN : S_IDLE;
        end else if (ls.ls_grant) begin
          w_fpc_nx   = r_fetch_pc + PC_WIDTH'(2);
          w_state_nx = S_WAIT;
        end
      end
      S_WAIT: begin
        if (i_branch_taken) begin
          w_fpc_nx   = i_branch_target;
          w_state_nx = ls.ls_rvalid ? S_IDLE : S_DRAIN;
        end else if (ls.ls_rvalid) begin
          w_state_nx = w_room ? S_REQ : S_IDLE;
        end
      end
      S_DRAIN: begin
        if (i_branch_taken)
          w_fpc_nx = i_branch_target;
        if (ls.ls_rvalid)
          w_state_nx = S_REQ;
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= S_IDLE;
      r_fetch_pc <= '0;
      r_line_pc  <= '0;
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        r_instr[i] <= '0;
        r_pc[i]    <= '0;
      end
    end else begin
      r_state    <= w_state_nx;
      r_fetch_pc <= w_fpc_nx;
      r_count    <= w_count_nx;
      if (w_grant)
        r_line_pc <= r_fetch_pc;
      if (i_branch_taken) begin
        r_tail <= r_head;
      end else begin
        r_head <= r_head + w_pop[AW-1:0];
        if (w_wr) begin
          r_instr[r_tail]          <= ls.ls_rdata[INSTR_W-1:0];
          r_instr[r_tail+AW'(1)]   <= ls.ls_rdata[2*INSTR_W-1:INSTR_W];
          r_pc[r_tail]             <= r_line_pc;
          r_pc[r_tail+AW'(1)]      <= r_line_pc + PC_WIDTH'(1);
          r_tail                   <= r_tail + AW'(2);
        end
      end
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge i_clk) begin
    if (!i_reset && !i_stall && !i_branch_taken)
      assert (CW'(i_issue_count) <= r_count);
  end
`endif

  assign ls.ls_req  = (r_state == S_REQ);
  assign ls.ls_addr = r_fetch_pc;

  assign o_instr0 = r_instr[r_head];
  assign o_instr1 = r_instr[r_head+AW'(1)];
  assign o_pc0    = r_pc[r_head];
  assign o_valid0 = (r_count != '0);
  assign o_valid1 = (r_count >= CW'(2));

endmodule
